// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide controller:
// funct3 op encodings, FSM state encoding, default operand width and
// operand-signedness helpers.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_div_op(op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem_op(op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // rs1 is treated as signed; MUL's low half is sign-agnostic so it rides along
  function automatic logic a_is_signed(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is treated as signed (MULHSU takes rs2 unsigned)
  function automatic logic b_is_signed(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle for muldiv_ctrl.
// master: request producer / result consumer; slave: the controller.
interface muldiv_if #(
  parameter int unsigned XLEN = muldiv_pkg::XLEN_DEFAULT
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/muldiv_step.sv
// One-bit iteration step on the shared 2*XLEN accumulator.
// Multiply: acc = {partial, multiplier}; conditional add then shift right.
// Divide (only when MULDIV_DIV_EN is defined): acc = {remainder, quotient};
// shift left then restoring subtract of the divisor.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   b_i,
`ifdef MULDIV_DIV_EN
  input  logic              div_i,
`endif
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] mul_sum;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
`endif

  // next accumulator value for one iteration
  always_comb begin
    mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, b_i} : '0);
    acc_o   = {mul_sum, acc_i[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    // remainder < divisor holds each step, so the shifted remainder fits XLEN+1 bits
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, b_i};
    if (div_i) begin
      if (!diff[XLEN]) begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M iterative multiply/divide controller, one bit per cycle.
// FSM IDLE -> CALC -> DONE -> IDLE; operands are latched as magnitudes and
// the sign is restored on the final CALC cycle.
// Optional feature macro: MULDIV_DIV_EN (division support). Without it,
// division ops complete one edge after accept with a zero result.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  muldiv_if.slave  bus,
  output logic     busy
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  op_e               op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   data_q, data_d;

  op_e               req_op;
  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   result_fix;

  // decode incoming request into operand magnitudes and sign bits
  always_comb begin
    req_op = op_e'(bus.req_op);
    a_sgn  = a_is_signed(req_op) & bus.req_a[XLEN-1];
    b_sgn  = b_is_signed(req_op) & bus.req_b[XLEN-1];
    a_mag  = a_sgn ? -bus.req_a : bus.req_a;
    b_mag  = b_sgn ? -bus.req_b : bus.req_b;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i (acc_q),
    .b_i   (b_q),
`ifdef MULDIV_DIV_EN
    .div_i (is_div_op(op_q)),
`endif
    .acc_o (acc_step)
  );

  // sign fix-up and result selection applied to the last iteration's output
  always_comb begin
    prod_fix   = neg_q ? -acc_step : acc_step;
    result_fix = '0;
    case (op_q)
      OP_MUL:                       result_fix = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_fix = prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      OP_DIV, OP_DIVU: result_fix = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      OP_REM, OP_REMU: result_fix = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
`endif
      default:                      result_fix = '0;
    endcase
  end

  // next-state, iteration counter and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    neg_d   = neg_q;
    data_d  = data_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_d    = req_op;
            neg_d   = is_rem_op(req_op) ? a_sgn : (a_sgn ^ b_sgn);
            acc_d   = {{XLEN{1'b0}}, a_mag};
            b_d     = b_mag;
            cnt_d   = '0;
            state_d = S_CALC;
            if (is_div_op(req_op)) begin
`ifdef MULDIV_DIV_EN
              if (bus.req_b == '0) begin
                data_d  = is_rem_op(req_op) ? bus.req_a : '1;
                state_d = S_DONE;
              end else if (a_is_signed(req_op) && (bus.req_a == {1'b1, {(XLEN-1){1'b0}}})
                           && (bus.req_b == '1)) begin
                data_d  = is_rem_op(req_op) ? '0 : bus.req_a;
                state_d = S_DONE;
              end
`else
              data_d  = '0;
              state_d = S_DONE;
`endif
            end
          end
        end
        S_CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            cnt_d   = '0;
            data_d  = result_fix;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      data_q  <= data_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_data  = data_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl (XLEN = 32). Expected results come
// from a plain-arithmetic RV32M model. Latency is counted in rising edges,
// with the edge that samples the request handshake counted as edge 1.
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    ea = {32'd0, a};
    eb = {32'd0, b};
    if (op == 3'd0 || op == 3'd1 || op == 3'd2) ea = {{32{a[31]}}, a};
    if (op == 3'd0 || op == 3'd1)               eb = {{32{b[31]}}, b};
    p = ea * eb;
    r = 32'd0;
    case (op)
      3'd0: r = p[31:0];
      3'd1, 3'd2, 3'd3: r = p[63:32];
`ifdef MULDIV_DIV_EN
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a :
                (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      3'd7: r = (b == 0) ? a : a % b;
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op < 3'd4) return 33;
`ifdef MULDIV_DIV_EN
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one request from IDLE, scribble on operand inputs while busy,
  // wait (bounded) for the result and retire it. lat = 0 on timeout.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] data, output int lat);
    bus.req_op     = op;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_valid  = 1'b1;
    bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 100) begin
      bus.req_op = 3'($urandom);
      bus.req_a  = $urandom;
      bus.req_b  = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.resp_valid !== 1'b1) lat = 0;
    data = bus.resp_data;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    bus.req_op = 3'd0; bus.req_a = 32'd0; bus.req_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== 32'd0) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 0", bus.resp_data); end
  endtask

  task automatic test_mul_vectors();
    logic [2:0]  ops [3] = '{3'd0, 3'd1, 3'd3};
    logic [31:0] exps[3] = '{32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'h0000_0002};
    logic [31:0] d;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], 32'd3, 32'hFFFF_FFFB, d, lat);
      n_checks++; if (d !== exps[i]) begin n_fail++; $display("FAIL mul_vec%0d_data: got %h expected %h", i, d, exps[i]); end
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_vec%0d_latency: got %0d expected 33", i, lat); end
    end
  endtask

  task automatic test_div_vectors();
`ifdef MULDIV_DIV_EN
    logic [2:0]  ops [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [8] = '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd8, 32'd8, 32'd7, 32'd7,
                             32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [8] = '{32'd6, 32'd6, 32'd6, 32'd6, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps[8] = '{32'd0, 32'hFFFF_FFFB, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'd7,
                             32'h8000_0000, 32'd0};
    int          lats[8] = '{33, 33, 33, 33, 1, 1, 1, 1};
`else
    logic [2:0]  ops [2] = '{3'd4, 3'd7};
    logic [31:0] as  [2] = '{32'd8, 32'd9};
    logic [31:0] bs  [2] = '{32'd2, 32'd4};
    logic [31:0] exps[2] = '{32'd0, 32'd0};
    int          lats[2] = '{1, 1};
`endif
    logic [31:0] d;
    int lat;
    for (int i = 0; i < $size(ops); i++) begin
      do_op(ops[i], as[i], bs[i], d, lat);
      n_checks++; if (d !== exps[i]) begin n_fail++; $display("FAIL div_vec%0d_data: got %h expected %h", i, d, exps[i]); end
      n_checks++; if (lat !== lats[i]) begin n_fail++; $display("FAIL div_vec%0d_latency: got %0d expected %0d", i, lat, lats[i]); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, d, e;
    int lat, el;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      e  = model_res(op, a, b);
      el = model_lat(op, a, b);
      do_op(op, a, b, d, lat);
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL rand%0d_data op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, d, e); end
      n_checks++; if (lat !== el) begin n_fail++; $display("FAIL rand%0d_latency op=%0d: got %0d expected %0d", i, op, lat, el); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, e;
    int lat;
    a = $urandom; b = $urandom;
    e = model_res(3'd1, a, b);
    bus.req_op = 3'd1; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    // keep a junk request pending for the whole transaction
    bus.req_op = 3'd0; bus.req_a = $urandom; bus.req_b = $urandom;
    while (bus.resp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL bp_latency: got %0d expected 33", lat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, bus.resp_valid); end
      n_checks++; if (bus.resp_data !== e) begin n_fail++; $display("FAIL bp_hold_data%0d: got %h expected %h", i, bus.resp_data, e); end
      n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready%0d: got %b expected 0", i, bus.req_ready); end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_retire_idle: busy got %b expected 0", busy); end
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_same_cycle_accept: busy got %b expected 0", busy); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int lat, seen;
    bus.req_op = 3'd0; bus.req_a = $urandom; bus.req_b = $urandom; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_calc_busy: got %b expected 0", busy); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_calc_req_ready: got %b expected 1", bus.req_ready); end
    // flush beats a simultaneous request in IDLE
    bus.req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_beats_req: busy got %b expected 0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_resp: got %0d valid cycles expected 0", seen); end
    // flush while a result is waiting in DONE
    bus.req_op = 3'd3; bus.req_a = $urandom; bus.req_b = $urandom; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_done_valid: got %b expected 0", bus.resp_valid); end
    do_op(3'd0, 32'd2, 32'd3, d, lat);
    n_checks++; if (d !== 32'd6) begin n_fail++; $display("FAIL flush_after_mul: got %h expected 6", d); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL flush_after_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_rst_mid_calc();
    logic [31:0] a, b, d, e;
    int lat, seen;
    bus.req_op = 3'd3; bus.req_a = $urandom; bus.req_b = $urandom; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== 32'd0) begin n_fail++; $display("FAIL rst_async_data: got %h expected 0", bus.resp_data); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_req_ready: got %b expected 1", bus.req_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_resp: got %0d valid cycles expected 0", seen); end
    a = $urandom; b = $urandom;
    e = model_res(3'd2, a, b);
    do_op(3'd2, a, b, d, lat);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL rst_next_op: got %h expected %h", d, e); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul_vectors();
    test_div_vectors();
    test_backpressure();
    test_flush();
    test_rst_mid_calc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous abort of in-flight operation.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_op  input  3  RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have ports req_a and req_b  input  XLEN  rs1 and rs2 operands.
REQ-009 SHALL have port resp_valid  output  1  result present.
REQ-010 SHALL have port resp_ready  input  1  consumer takes result.
REQ-011 SHALL have port resp_data  output  XLEN  result.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; req_ready = (state==IDLE).
REQ-014 SHALL accept on req_valid&&req_ready edge: latch op, magnitudes of operands per signedness of op, and result-sign flag.
REQ-015 SHALL iterate one bit per cycle in CALC: shift-add multiply and restoring divide share one 2*XLEN accumulator and a 0..XLEN-1 counter.
REQ-016 SHALL apply sign fix-up (two's-complement negate) on the final CALC cycle and enter DONE; resp_valid rises exactly XLEN+1 edges after the accepting edge.
REQ-017 SHALL select low XLEN bits for MUL, high XLEN bits for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
REQ-018 SHALL treat MULHSU as rs1 signed, rs2 unsigned.
REQ-019 SHALL, on divisor zero, skip CALC, go IDLE->DONE in one edge with quotient all-ones and remainder = dividend.
REQ-020 SHALL, on signed overflow (dividend 2^(XLEN-1), divisor -1), skip CALC with DIV result = dividend, REM result = 0.
REQ-021 SHALL hold resp_valid and resp_data stable in DONE until resp_ready; DONE->IDLE on resp_valid&&resp_ready; no request accepted in that same cycle.
REQ-022 SHALL, on flush, go to IDLE at next edge from any state, discarding result; flush beats a simultaneous request (req_ready still high in IDLE but request not latched).
REQ-023 SHALL ignore req_op/req_a/req_b changes while busy.

Reset
REQ-024 SHALL on rst: state IDLE, counter 0, accumulator 0, resp_valid 0, resp_data 0, busy 0, req_ready 1 (after reset released).
REQ-025 SHALL abort any operation when rst asserts mid-CALC or mid-DONE; no result is ever presented for it.

Configuration
REQ-026 SHALL compile division (DIV/DIVU/REM/REMU, REQ-019, REQ-020) only when MULDIV_DIV_EN is defined.
REQ-027 SHALL, without MULDIV_DIV_EN, accept division ops and return resp_data 0 one edge after accept; multiply behaviour unchanged.

Structure
REQ-028 SHALL take funct3 op encodings, FSM state encoding and XLEN default from shared package muldiv_pkg.
REQ-029 SHALL place one-bit iteration datapath (add/subtract-and-shift step) in sub-module muldiv_step; FSM, counter and fix-up stay in muldiv_ctrl.

Verification
REQ-030 SHALL check MUL 3 x 0xFFFFFFFB -> 0xFFFFFFF1; MULH same -> 0xFFFFFFFF; MULHU same -> 0x00000002; resp_valid at accept+33 edges.
REQ-031 SHALL check DIV 0xFFFFFFFB/6 -> 0x00000000, REM -> 0xFFFFFFFB; DIVU 8/6 -> 1, REMU -> 2.
REQ-032 SHALL check DIV 7/0 -> 0xFFFFFFFF, REM 7/0 -> 7, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, each with resp_valid one edge after accept.
REQ-033 SHALL check resp_ready held low 10 cycles in DONE -> resp_valid/resp_data stable, req_ready low throughout.
REQ-034 SHALL check flush at CALC cycle 5 -> IDLE next edge, no resp_valid; subsequent MUL 2 x 3 -> 6.
REQ-035 SHALL check rst pulse mid-CALC -> all outputs at reset values, next request completes correctly; build without MULDIV_DIV_EN -> DIV 8/2 returns 0.
